pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch front end of the RV32 core. Holds the architectural fetch PC, issues one outstanding request at a time to instruction memory over a req/ready + rvalid handshake, and delivers fetched words with their PC to decode. Consumes the JALR target sum and the branch/JAL target from execute as redirects; clears bit 0 of the JALR target and traps on misaligned targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Stall  in  1  decode cannot accept; hold delivered instruction, issue no new request
- JalrTaken  in  1  execute resolves a JALR this cycle
- JalrTarget  in  32  raw Rs1+imm sum from the JALR adder
- BranchTaken  in  1  execute resolves a taken branch or JAL this cycle
- BranchTarget  in  32  branch/JAL target
- ImemReq  out  1  fetch request valid
- ImemAddr  out  32  fetch address (= PC register)
- ImemReady  in  1  memory accepts request this cycle
- ImemRvalid  in  1  read data valid
- ImemRdata  in  32  instruction word
- InstrValid  out  1  Instr/InstrPc valid for decode
- Instr  out  32  instruction to decode
- InstrPc  out  32  address of Instr
- MisalignTrap  out  1  one-cycle pulse: redirect target not 4-byte aligned

## Operation
- Reset (async, rst_n=0): PC=RESET_PC, state=S_REQ, ImemReq=0 while in reset, InstrValid=0, Instr=32'h0000_0013 (NOP), InstrPc=0, MisalignTrap=0, hold buffer empty.
- Redirect = JalrTaken | BranchTaken; JalrTaken has priority. Target = {JalrTarget[31:1],1'b0} or BranchTarget. If target[1]=1: PC<=TRAP_VEC, MisalignTrap=1 next cycle; else PC<=target.
- Redirect overrides Stall and every state; it always clears InstrValid (to 0) and empties the hold buffer.
- States:
  - S_REQ: ImemReq = !Stall. Accept = ImemReq & ImemReady -> latch ReqPc=PC, PC<=PC+4 (wraps mod 2^32), go S_WAIT. Redirect same cycle as accept -> PC<=target, go S_KILL (accepted request is stale).
  - S_WAIT: on ImemRvalid & !Stall -> Instr<=ImemRdata, InstrPc<=ReqPc, InstrValid<=1, go S_REQ. On ImemRvalid & Stall -> store word+ReqPc in hold buffer, go S_HOLD. Redirect without rvalid -> S_KILL; redirect with rvalid -> discard, S_REQ.
  - S_KILL: ImemReq=0; on ImemRvalid discard word, go S_REQ. Redirect here reloads PC, stays S_KILL.
  - S_HOLD: ImemReq=0; when Stall=0 -> present buffer (InstrValid<=1), go S_REQ. Redirect -> discard, S_REQ.
- Decode outputs: while Stall=1 and no redirect, InstrValid/Instr/InstrPc hold. When Stall=0 and nothing delivered, InstrValid<=0.
- ImemRvalid in S_REQ is a protocol error; ignore it.

## Timing
- Accept in cycle N; earliest ImemRvalid N+1; InstrValid high N+2. Peak throughput one instruction per 2 cycles.
- Redirect in cycle N -> ImemAddr = new target in N+1; MisalignTrap high in N+1 only.
- All outputs are registered except ImemReq (state & !Stall) and ImemAddr (PC register).
- Reset mid-transaction: in-flight response after rst_n rises is treated as S_REQ-state rvalid (ignored).

## Structure
- rv32_core_pkg: fetch state enum (S_REQ, S_WAIT, S_KILL, S_HOLD), NOP_INSTR = 32'h0000_0013, XLEN = 32.
- Sub-module next_pc_sel (combinational): redirect priority, bit-0 clear, misalign detect, PC+4. Registers and FSM live in pc_fetch_unit.

## Test plan
- Reset, ImemReady=1, rvalid one cycle after each accept with data 0xA0+k -> ImemAddr 0x0,0x4,0x8; InstrPc matches, InstrValid every second cycle.
- JalrTaken with JalrTarget=0x0000_0105 while in S_WAIT -> S_KILL, pending word dropped, next ImemAddr=0x104, no trap.
- BranchTaken with BranchTarget=0x0000_0202 -> MisalignTrap one cycle, next ImemAddr=0x100.
- Stall=1 when rvalid returns 0x0000_0033 -> InstrValid not updated, no new ImemReq; Stall drop -> Instr=0x33 with correct InstrPc, then fetch resumes at PC+4.
- JalrTaken and BranchTaken same cycle (0x400 / 0x800) -> PC=0x400; redirect coincident with rvalid -> word discarded, InstrValid=0.
- PC=0xFFFF_FFFC accepted -> next ImemAddr=0x0000_0000; rst_n pulsed low in S_WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/rv32_core_pkg.sv
// ============================================================================
// Module      : rv32_core_pkg
// Description : Shared types and constants for the RV32 core front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage : rv32_core_pkg

`default_nettype wire

// File: rtl/next_pc_sel.sv
// ============================================================================
// Module      : next_pc_sel
// Description : Redirect selection, JALR bit-0 clear, misalign detect, PC+4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_sel
    import rv32_core_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_jalr_taken,
    input  logic [XLEN-1:0] i_jalr_target,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic            o_redirect,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [XLEN-1:0] o_pc_plus4
);

    logic [XLEN-1:0] w_target;
    logic            w_unused;

    // JALR wins when both resolve together
    assign w_target      = i_jalr_taken ? {i_jalr_target[XLEN-1:1], 1'b0} : i_branch_target;
    assign w_unused      = i_jalr_target[0];
    assign o_redirect    = i_jalr_taken | i_branch_taken;
    assign o_misalign    = w_target[1];
    assign o_redirect_pc = w_target[1] ? TRAP_VEC : w_target;
    assign o_pc_plus4    = i_pc + 32'd4;

endmodule : next_pc_sel

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : RV32 fetch PC and single-outstanding instruction fetch FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import rv32_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        JalrTaken,
    input  logic [31:0] JalrTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPc,
    output logic        MisalignTrap
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_trap;

    logic        w_redirect;
    logic        w_misalign;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_plus4;
    logic        w_accept;
    logic        w_deliver_mem;
    logic        w_deliver_hold;
    logic        w_hold_store;

    next_pc_sel #(
        .TRAP_VEC        (TRAP_VEC)
    ) u_next_pc_sel (
        .i_pc            (r_pc),
        .i_jalr_taken    (JalrTaken),
        .i_jalr_target   (JalrTarget),
        .i_branch_taken  (BranchTaken),
        .i_branch_target (BranchTarget),
        .o_redirect      (w_redirect),
        .o_misalign      (w_misalign),
        .o_redirect_pc   (w_redirect_pc),
        .o_pc_plus4      (w_pc_plus4)
    );

    assign w_accept       = ImemReq & ImemReady;
    assign w_deliver_mem  = (r_state == S_WAIT) & ImemRvalid & ~Stall & ~w_redirect;
    assign w_deliver_hold = (r_state == S_HOLD) & ~Stall & ~w_redirect;
    assign w_hold_store   = (r_state == S_WAIT) & ImemRvalid & Stall & ~w_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_state_next = w_redirect ? S_KILL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ImemRvalid) begin
                    w_state_next = (Stall && !w_redirect) ? S_HOLD : S_REQ;
                end else if (w_redirect) begin
                    w_state_next = S_KILL;
                end
            end
            S_KILL: begin
                // A stale response must drain before a new request may issue
                if (ImemRvalid) begin
                    w_state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (w_redirect || !Stall) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase
    end

    always_comb begin
        ImemReq  = rst_n & (r_state == S_REQ) & ~Stall;
        ImemAddr = r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_hold_instr  <= NOP_INSTR;
            r_hold_pc     <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_trap        <= 1'b0;
        end else begin
            r_trap <= w_redirect & w_misalign;
            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= w_pc_plus4;
            end
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            if (w_hold_store) begin
                r_hold_instr <= ImemRdata;
                r_hold_pc    <= r_req_pc;
            end
            if (w_redirect) begin
                r_instr_valid <= 1'b0;
            end else if (w_deliver_mem) begin
                r_instr_valid <= 1'b1;
                r_instr       <= ImemRdata;
                r_instr_pc    <= r_req_pc;
            end else if (w_deliver_hold) begin
                r_instr_valid <= 1'b1;
                r_instr       <= r_hold_instr;
                r_instr_pc    <= r_hold_pc;
            end else if (!Stall) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign InstrValid   = r_instr_valid;
    assign Instr        = r_instr;
    assign InstrPc      = r_instr_pc;
    assign MisalignTrap = r_trap;

endmodule : pc_fetch_unit

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Randomized self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall = 1'b1;
    logic        JalrTaken = 1'b0;
    logic [31:0] JalrTarget = '0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady = 1'b0;
    logic        ImemRvalid = 1'b0;
    logic [31:0] ImemRdata = '0;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPc;
    logic        MisalignTrap;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: fetch PC, one outstanding request, hold buffer as a queue
    logic [31:0] m_pc;
    logic        m_pending;
    logic        m_stale;
    logic [31:0] m_req_pc;
    logic [63:0] m_held[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_trap;

    // memory side
    logic        mem_out  = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_data = '0;
    int          lat_max  = 1;
    bit          rand_data = 1'b0;
    logic [31:0] next_data = 32'h0000_00A0;

    pc_fetch_unit #(
        .RESET_PC     (C_RESET_PC),
        .TRAP_VEC     (C_TRAP_VEC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Stall        (Stall),
        .JalrTaken    (JalrTaken),
        .JalrTarget   (JalrTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemReady    (ImemReady),
        .ImemRvalid   (ImemRvalid),
        .ImemRdata    (ImemRdata),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPc      (InstrPc),
        .MisalignTrap (MisalignTrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_req();
        return !m_pending && (m_held.size() == 0) && !Stall;
    endfunction

    task automatic model_reset();
        m_pc      = C_RESET_PC;
        m_pending = 1'b0;
        m_stale   = 1'b0;
        m_req_pc  = '0;
        m_held.delete();
        m_valid   = 1'b0;
        m_instr   = C_NOP;
        m_ipc     = '0;
        m_trap    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Stall = 1'b1; JalrTaken = 1'b0; BranchTaken = 1'b0;
        ImemReady = 1'b0; ImemRvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_req",   {31'd0, ImemReq},      32'd0);
        chk("rst_addr",  ImemAddr,              C_RESET_PC);
        chk("rst_valid", {31'd0, InstrValid},   32'd0);
        chk("rst_instr", Instr,                 C_NOP);
        chk("rst_ipc",   InstrPc,               32'd0);
        chk("rst_trap",  {31'd0, MisalignTrap}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one clock: drive inputs, check outputs, then advance the model at the edge
    task automatic cycle(input logic st, input logic jt, input logic [31:0] jtg,
                         input logic bt, input logic [31:0] btg, input logic rdy);
        logic        redir, acc, rv, er;
        logic [31:0] tgt;
        @(negedge clk);
        Stall = st; JalrTaken = jt; JalrTarget = jtg;
        BranchTaken = bt; BranchTarget = btg;
        ImemReady = rdy & !(mem_out && !m_pending);
        if (mem_out && mem_wait == 0) begin
            ImemRvalid = 1'b1;
            ImemRdata  = mem_data;
        end else begin
            ImemRvalid = 1'b0;
            ImemRdata  = $urandom;
            if (mem_out) mem_wait--;
        end
        #1;
        er = exp_req();
        chk("req",   {31'd0, ImemReq},      {31'd0, er});
        chk("addr",  ImemAddr,              m_pc);
        chk("valid", {31'd0, InstrValid},   {31'd0, m_valid});
        chk("instr", Instr,                 m_instr);
        chk("ipc",   InstrPc,               m_ipc);
        chk("trap",  {31'd0, MisalignTrap}, {31'd0, m_trap});
        @(posedge clk);
        redir = jt | bt;
        tgt   = jt ? (jtg & 32'hFFFF_FFFE) : btg;
        acc   = er & ImemReady;
        rv    = ImemRvalid & m_pending;
        m_trap = redir & tgt[1];
        if (ImemRvalid) mem_out = 1'b0;
        if (acc) begin
            mem_out   = 1'b1;
            mem_wait  = $urandom_range(1, lat_max) - 1;
            mem_data  = rand_data ? $urandom : next_data;
            next_data = next_data + 1;
            m_req_pc  = m_pc;
        end
        if (redir) begin
            m_pc    = tgt[1] ? C_TRAP_VEC : tgt;
            m_valid = 1'b0;
            m_held.delete();
            if (acc) begin
                m_pending = 1'b1; m_stale = 1'b1;
            end else if (rv) begin
                m_pending = 1'b0;
            end else if (m_pending) begin
                m_stale = 1'b1;
            end
        end else begin
            if (acc) begin
                m_pc = m_pc + 32'd4;
                m_pending = 1'b1; m_stale = 1'b0;
            end
            if (rv && !m_stale && st) begin
                m_held.push_back({ImemRdata, m_req_pc});
            end
            if (rv && !m_stale && !st) begin
                m_valid = 1'b1; m_instr = ImemRdata; m_ipc = m_req_pc;
            end else if (!rv && m_held.size() != 0 && !st) begin
                m_valid = 1'b1;
                m_instr = m_held[0][63:32];
                m_ipc   = m_held[0][31:0];
                m_held.delete();
            end else if (!st) begin
                m_valid = 1'b0;
            end
            if (rv) m_pending = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // straight-line fetch, one-cycle memory
        repeat (7) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // JALR while waiting on a slow response, bit 0 cleared
        lat_max = 3;
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0105, 1'b0, '0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // misaligned branch target traps
        lat_max = 1;
        cycle(1'b0, 1'b0, '0, 1'b1, 32'h0000_0202, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // stall while the response returns, then release
        next_data = 32'h0000_0033;
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // simultaneous JALR and branch, and redirect coincident with rvalid
        cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0800, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 32'h0000_0040, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // PC wrap at top of address space
        cycle(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // reset while a slow request is in flight
        lat_max = 3;
        mem_out = 1'b0;
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        do_reset();
        repeat (6) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // randomized traffic
        rand_data = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0), $urandom,
                  ($urandom_range(0, 9) == 0), $urandom,
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_unit

`default_nettype wire
